pwm_ctrl_sequencer: RTL
=======================

// Module: pwm_ctrl_sequencer
// PURPOSE
//   Sequences the PWM datapath from the AXI4-Lite register file of the pwm_test IP.
//   Double-buffers period/duty and applies updates only at period boundaries (glitch-free).
//   Supplies prescaling, one-shot mode and graceful stop. Sits between slv_reg outputs and the pin.
// PARAMETERS
//   C_CNT_WIDTH       32  width of period/duty/counter
//   C_PRESCALE_WIDTH  8   width of prescaler reload value
//   C_DEADTIME        4   dead-time in ACLK cycles (used only with PWM_DEADTIME_EN)
// PORTS
//   ACLK            in   1                 clock
//   ARESET          in   1                 asynchronous, active-high reset
//   cfg_enable      in   1                 run request (slv_reg0[0])
//   cfg_oneshot     in   1                 single period then stop (slv_reg0[1])
//   cfg_period      in   C_CNT_WIDTH       period in ticks (slv_reg1)
//   cfg_duty        in   C_CNT_WIDTH       high time in ticks (slv_reg2)
//   cfg_prescale    in   C_PRESCALE_WIDTH  tick = every cfg_prescale+1 ACLK cycles (slv_reg3)
//   cfg_update      in   1                 1-cycle pulse: period/duty/prescale rewritten
//   pwm_out         out  1                 PWM output, registered
//   pwm_out_n       out  1                 complementary output (PWM_DEADTIME_EN only)
//   period_tick     out  1                 1-cycle pulse at each period boundary
//   busy            out  1                 state in {LOAD,RUN,STOP}
//   update_pending  out  1                 cfg_update seen, not yet applied
// BEHAVIOUR
//   - Reset: all outputs 0, state IDLE, counters and shadows 0; takes effect immediately (async).
//   - States: IDLE, LOAD, RUN, STOP, DONE.
//   - IDLE: pwm_out=0. cfg_enable=1 and cfg_period!=0 -> LOAD; cfg_period==0 -> stay IDLE.
//   - LOAD (1 cycle): shadows <= cfg_period/duty/prescale; cnt<=0; presc<=0; pending<=0 -> RUN.
//     Enable sampled at edge N -> first pwm_out value driven at edge N+2.
//   - RUN: tick when presc==shadow_prescale (presc wraps to 0), else presc++.
//     pwm_out <= (cnt < shadow_duty); duty=0 -> constant 0; duty>=period -> constant 1.
//     On tick with cnt==shadow_period-1: cnt<=0, period_tick=1 for one cycle (boundary).
//   - Boundary: if pending or cfg_update same cycle, shadows <= cfg values, pending<=0.
//     New shadow_period==0 -> IDLE. cfg_oneshot=1 -> DONE. Otherwise stay RUN.
//   - cfg_enable=0 in RUN -> STOP: continues current period unchanged, -> IDLE at boundary
//     (period_tick still pulses). cfg_enable=1 again in STOP -> RUN, no glitch, no reload.
//   - DONE: pwm_out=0, busy=0; stays until cfg_enable=0 -> IDLE.
//   - cfg_update: sets pending in RUN/STOP; repeated pulses keep pending, latest cfg used.
//     Ignored in IDLE/LOAD/DONE (LOAD samples cfg directly).
//   - Counter compare unsigned, full C_CNT_WIDTH; cnt never exceeds shadow_period-1.
//   - Async reset mid-period: pwm_out drops to 0 without waiting for a boundary.
// CONFIGURATION
//   PWM_DEADTIME_EN defined: pwm_out_n present; raw PWM drives a complementary pair;
//     each output's rising edge is delayed C_DEADTIME cycles after the other falls;
//     both 0 in reset/IDLE/DONE; pulses shorter than C_DEADTIME are suppressed on that side.
//   PWM_DEADTIME_EN undefined: no pwm_out_n port, C_DEADTIME unused, pwm_out = raw PWM.
// TESTING
//   1. Assert ARESET mid-RUN -> pwm_out, period_tick, busy, update_pending all 0 same cycle.
//   2. period=10,duty=3,prescale=0,enable -> pwm_out 3 high/7 low, period_tick every 10 cycles.
//   3. period=4,duty=2,prescale=1 -> 4 cycles high, 4 low, period_tick every 8 cycles.
//   4. Mid-period cfg_update duty=8 -> current period keeps 3; next period 8 high; pending high until tick.
//   5. oneshot=1,period=5,duty=2 -> exactly one period_tick, then DONE, busy=0; enable=0 -> IDLE.
//   6. Disable at cnt=5 of period=10 -> period completes, then IDLE, pwm_out=0; duty=12,period=10 -> constant 1.

Source files
------------

// File: rtl/pwm_ctrl_sequencer_if.sv
// rtl/pwm_ctrl_sequencer_if.sv - register-side config and status bundle for pwm_ctrl_sequencer
// pwm_out_n exists only when PWM_DEADTIME_EN is defined.
interface pwm_ctrl_sequencer_if #(
    parameter int C_CNT_WIDTH      = 32,
    parameter int C_PRESCALE_WIDTH = 8
);
    logic                        cfg_enable;
    logic                        cfg_oneshot;
    logic [C_CNT_WIDTH-1:0]      cfg_period;
    logic [C_CNT_WIDTH-1:0]      cfg_duty;
    logic [C_PRESCALE_WIDTH-1:0] cfg_prescale;
    logic                        cfg_update;
    logic                        pwm_out;
`ifdef PWM_DEADTIME_EN
    logic                        pwm_out_n;
`endif
    logic                        period_tick;
    logic                        busy;
    logic                        update_pending;

    modport master (
        output cfg_enable,
        output cfg_oneshot,
        output cfg_period,
        output cfg_duty,
        output cfg_prescale,
        output cfg_update,
        input  pwm_out,
        input  period_tick,
        input  busy,
        input  update_pending
`ifdef PWM_DEADTIME_EN
        , input pwm_out_n
`endif
    );

    modport slave (
        input  cfg_enable,
        input  cfg_oneshot,
        input  cfg_period,
        input  cfg_duty,
        input  cfg_prescale,
        input  cfg_update,
        output pwm_out,
        output period_tick,
        output busy,
        output update_pending
`ifdef PWM_DEADTIME_EN
        , output pwm_out_n
`endif
    );
endinterface

// File: rtl/pwm_ctrl_sequencer.sv
// rtl/pwm_ctrl_sequencer.sv - double-buffered PWM sequencer with prescaler, one-shot and graceful stop
// Optional complementary output with dead-time when PWM_DEADTIME_EN is defined.
module pwm_ctrl_sequencer #(
    parameter int C_CNT_WIDTH      = 32,
    parameter int C_PRESCALE_WIDTH = 8,
    parameter int C_DEADTIME       = 4
) (
    input  logic ACLK,
    input  logic ARESET,
    pwm_ctrl_sequencer_if.slave bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_STOP = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]                  state;
    logic [C_CNT_WIDTH-1:0]      cnt;
    logic [C_CNT_WIDTH-1:0]      shadow_period;
    logic [C_CNT_WIDTH-1:0]      shadow_duty;
    logic [C_PRESCALE_WIDTH-1:0] presc;
    logic [C_PRESCALE_WIDTH-1:0] shadow_prescale;
    logic                        pending;
    logic                        pwm_raw;
    logic                        period_tick_q;

    logic                        counting;
    logic                        tick;
    logic                        boundary;
    logic                        take_cfg;
    logic [C_CNT_WIDTH-1:0]      next_period;

    assign counting    = (state == S_RUN) || (state == S_STOP);
    assign tick        = counting && (presc == shadow_prescale);
    assign boundary    = tick && (cnt == shadow_period - C_CNT_WIDTH'(1));
    assign take_cfg    = pending || bus.cfg_update;
    assign next_period = take_cfg ? bus.cfg_period : shadow_period;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state           <= S_IDLE;
            cnt             <= '0;
            presc           <= '0;
            shadow_period   <= '0;
            shadow_duty     <= '0;
            shadow_prescale <= '0;
            pending         <= 1'b0;
            pwm_raw         <= 1'b0;
            period_tick_q   <= 1'b0;
        end else begin
            period_tick_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    pwm_raw <= 1'b0;
                    pending <= 1'b0;
                    if (bus.cfg_enable && (bus.cfg_period != '0))
                        state <= S_LOAD;
                end
                S_LOAD: begin
                    shadow_period   <= bus.cfg_period;
                    shadow_duty     <= bus.cfg_duty;
                    shadow_prescale <= bus.cfg_prescale;
                    cnt             <= '0;
                    presc           <= '0;
                    pending         <= 1'b0;
                    pwm_raw         <= 1'b0;
                    state           <= S_RUN;
                end
                S_RUN, S_STOP: begin
                    // duty >= period naturally yields constant 1 since cnt <= period-1
                    pwm_raw <= (cnt < shadow_duty);
                    presc   <= tick ? '0 : presc + C_PRESCALE_WIDTH'(1);
                    if (boundary) begin
                        cnt           <= '0;
                        period_tick_q <= 1'b1;
                        pending       <= 1'b0;
                        if (take_cfg) begin
                            shadow_period   <= bus.cfg_period;
                            shadow_duty     <= bus.cfg_duty;
                            shadow_prescale <= bus.cfg_prescale;
                        end
                        if (!bus.cfg_enable || (next_period == '0))
                            state <= S_IDLE;
                        else if (bus.cfg_oneshot)
                            state <= S_DONE;
                        else
                            state <= S_RUN;
                    end else begin
                        if (tick)
                            cnt <= cnt + C_CNT_WIDTH'(1);
                        if (bus.cfg_update)
                            pending <= 1'b1;
                        state <= bus.cfg_enable ? S_RUN : S_STOP;
                    end
                end
                S_DONE: begin
                    pwm_raw <= 1'b0;
                    pending <= 1'b0;
                    if (!bus.cfg_enable)
                        state <= S_IDLE;
                end
                default: begin
                    state   <= S_IDLE;
                    pwm_raw <= 1'b0;
                end
            endcase
        end
    end

    assign bus.period_tick    = period_tick_q;
    assign bus.busy           = (state == S_LOAD) || (state == S_RUN) || (state == S_STOP);
    assign bus.update_pending = pending;

`ifdef PWM_DEADTIME_EN
    localparam int DT_W = $clog2(C_DEADTIME + 2);
    localparam logic [DT_W-1:0] DT_MAX = DT_W'(C_DEADTIME);

    logic            raw_active;
    logic [DT_W-1:0] hi_run;
    logic [DT_W-1:0] lo_run;
    logic            out_p;
    logic            out_n;

    // Each side must see its raw level held for C_DEADTIME cycles before rising;
    // shorter pulses never reach the saturation point and are dropped.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            raw_active <= 1'b0;
            hi_run     <= '0;
            lo_run     <= '0;
            out_p      <= 1'b0;
            out_n      <= 1'b0;
        end else begin
            raw_active <= counting;
            if (raw_active && pwm_raw) begin
                if (hi_run != DT_MAX)
                    hi_run <= hi_run + DT_W'(1);
            end else begin
                hi_run <= '0;
            end
            if (raw_active && !pwm_raw) begin
                if (lo_run != DT_MAX)
                    lo_run <= lo_run + DT_W'(1);
            end else begin
                lo_run <= '0;
            end
            out_p <= raw_active && pwm_raw && (hi_run == DT_MAX);
            out_n <= raw_active && !pwm_raw && (lo_run == DT_MAX);
        end
    end

    assign bus.pwm_out   = out_p;
    assign bus.pwm_out_n = out_n;
`else
    logic unused_deadtime;
    assign unused_deadtime = (C_DEADTIME != 0);
    assign bus.pwm_out     = pwm_raw;
`endif
endmodule
